// File: rtl/mem_wb_stage_if.sv
// mem_wb_stage_if: groups the EXE/MEM -> MEM/WB signals for the memory stage.
//   Inputs to the stage (driven by master):  malu, mb, mrn, mwreg, mm2reg, mwmem
//   Outputs of the stage (driven by slave):  wmo, walu, wrn, wwreg, wm2reg, walign_err
//   modport master : upstream pipeline / testbench side
//   modport slave  : mem_wb_stage side
interface mem_wb_stage_if;
  logic [31:0] malu;
  logic [31:0] mb;
  logic [4:0]  mrn;
  logic        mwreg;
  logic        mm2reg;
  logic        mwmem;
  logic [31:0] wmo;
  logic [31:0] walu;
  logic [4:0]  wrn;
  logic        wwreg;
  logic        wm2reg;
  logic        walign_err;

  modport master (
    output malu, mb, mrn, mwreg, mm2reg, mwmem,
    input  wmo, walu, wrn, wwreg, wm2reg, walign_err
  );

  modport slave (
    input  malu, mb, mrn, mwreg, mm2reg, mwmem,
    output wmo, walu, wrn, wwreg, wm2reg, walign_err
  );
endinterface

// File: rtl/mem_wb_stage.sv
// mem_wb_stage: memory-access stage with word-addressed data RAM and the
// MEM/WB pipeline register.
//   clk  : pipeline clock, rising edge
//   rst  : synchronous active-high reset (clears MEM/WB outputs, blocks stores;
//          RAM contents are retained)
//   bus  : mem_wb_stage_if.slave
//          in : malu (byte address / ALU value), mb (store data), mrn, mwreg,
//               mm2reg, mwmem
//          out: wmo (registered read data), walu, wrn, wwreg, wm2reg, walign_err
//   ADDR_WIDTH : word-address width, RAM depth 2**ADDR_WIDTH x 32
// Optional feature macro: MEM_ALIGN_CHECK_EN -- when defined, accesses with
// malu[1:0] != 0 have their store suppressed, wwreg forced low and walign_err
// flagged for one cycle. When undefined, walign_err is constant 0.
module mem_wb_stage #(
  parameter int unsigned ADDR_WIDTH = 8
) (
  input  logic           clk,
  input  logic           rst,
  mem_wb_stage_if.slave  bus
);

  localparam int unsigned DEPTH = 1 << ADDR_WIDTH;

  logic [31:0]           mem [DEPTH];
  logic [ADDR_WIDTH-1:0] idx;
  logic [31:0]           rdata;
  logic                  misalign;
  logic                  store_en;

  logic [31:0] wmo_q;
  logic [31:0] walu_q;
  logic [4:0]  wrn_q;
  logic        wwreg_q;
  logic        wm2reg_q;

  // Upper address bits alias; low bits only matter to the alignment check.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{bus.malu[31:ADDR_WIDTH+2], bus.malu[1:0]};

  assign idx   = bus.malu[ADDR_WIDTH+1:2];
  assign rdata = mem[idx];

`ifdef MEM_ALIGN_CHECK_EN
  assign misalign = (bus.malu[1:0] != 2'b00) && (bus.mwmem || bus.mm2reg);
`else
  assign misalign = 1'b0;
`endif

  assign store_en = bus.mwmem && !misalign;

  // RAM is never reset; only the store is gated by rst.
  always_ff @(posedge clk) begin
    if (!rst && store_en) begin
      mem[idx] <= bus.mb;
    end
  end

  // rdata is the pre-store word, giving old-data read-during-write.
  always_ff @(posedge clk) begin
    if (rst) begin
      wmo_q    <= '0;
      walu_q   <= '0;
      wrn_q    <= '0;
      wwreg_q  <= 1'b0;
      wm2reg_q <= 1'b0;
    end else begin
      wmo_q    <= rdata;
      walu_q   <= bus.malu;
      wrn_q    <= bus.mrn;
      wwreg_q  <= bus.mwreg && !misalign;
      wm2reg_q <= bus.mm2reg;
    end
  end

`ifdef MEM_ALIGN_CHECK_EN
  logic err_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      err_q <= 1'b0;
    end else begin
      err_q <= misalign;
    end
  end

  assign bus.walign_err = err_q;
`else
  assign bus.walign_err = 1'b0;
`endif

  assign bus.wmo    = wmo_q;
  assign bus.walu   = walu_q;
  assign bus.wrn    = wrn_q;
  assign bus.wwreg  = wwreg_q;
  assign bus.wm2reg = wm2reg_q;

endmodule

// File: tb/tb_mem_wb_stage.sv
// tb_mem_wb_stage: table-driven vectors plus a short randomized stream for
// mem_wb_stage (ADDR_WIDTH=8). Expected results are queued when stimulus is
// driven and compared one cycle later against the MEM/WB outputs.
module tb_mem_wb_stage;

  logic clk;
  logic rst;

  mem_wb_stage_if bus ();

  mem_wb_stage #(.ADDR_WIDTH(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit          rst;
    logic [31:0] malu;
    logic [31:0] mb;
    logic [4:0]  mrn;
    bit          mwreg;
    bit          mm2reg;
    bit          mwmem;
    bit          chk_wmo;
    logic [31:0] exp_wmo;
    string       name;
  } vec_t;

  typedef struct {
    bit          chk_wmo;
    logic [31:0] wmo;
    logic [31:0] walu;
    logic [4:0]  wrn;
    logic        wwreg;
    logic        wm2reg;
    logic        err;
    string       name;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] model_mem [256];
  bit          known [256];

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic step(input vec_t v);
    exp_t        e;
    logic [7:0]  idx;
    bit          mis;
    idx = v.malu[9:2];
`ifdef MEM_ALIGN_CHECK_EN
    mis = (v.malu[1:0] != 2'b00) && (v.mwmem || v.mm2reg);
`else
    mis = 1'b0;
`endif
    e.name = v.name;
    if (v.rst) begin
      e.chk_wmo = 1'b1;
      e.wmo     = '0;
      e.walu    = '0;
      e.wrn     = '0;
      e.wwreg   = 1'b0;
      e.wm2reg  = 1'b0;
      e.err     = 1'b0;
    end else begin
      e.walu   = v.malu;
      e.wrn    = v.mrn;
      e.wwreg  = v.mwreg && !mis;
      e.wm2reg = v.mm2reg;
      e.err    = mis;
      if (v.chk_wmo) begin
        e.chk_wmo = 1'b1;
        e.wmo     = v.exp_wmo;
      end else begin
        e.chk_wmo = known[idx];
        e.wmo     = model_mem[idx];
      end
      if (v.mwmem && !mis) begin
        model_mem[idx] = v.mb;
        known[idx]     = 1'b1;
      end
    end
    sb.push_back(e);

    rst        = v.rst;
    bus.malu   = v.malu;
    bus.mb     = v.mb;
    bus.mrn    = v.mrn;
    bus.mwreg  = v.mwreg;
    bus.mm2reg = v.mm2reg;
    bus.mwmem  = v.mwmem;
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      errors++;
      $display("FAIL %s: scoreboard empty", v.name);
    end else begin
      e = sb.pop_front();
      if (e.chk_wmo) chk({e.name, ".wmo"}, bus.wmo, e.wmo);
      chk({e.name, ".walu"},       bus.walu,                e.walu);
      chk({e.name, ".wrn"},        {27'd0, bus.wrn},        {27'd0, e.wrn});
      chk({e.name, ".wwreg"},      {31'd0, bus.wwreg},      {31'd0, e.wwreg});
      chk({e.name, ".wm2reg"},     {31'd0, bus.wm2reg},     {31'd0, e.wm2reg});
      chk({e.name, ".walign_err"}, {31'd0, bus.walign_err}, {31'd0, e.err});
    end
  endtask

  function automatic vec_t mk(input bit r, input logic [31:0] a, input logic [31:0] d,
                              input logic [4:0] rn, input bit wr, input bit m2r, input bit wm,
                              input bit cw, input logic [31:0] ew, input string n);
    vec_t v;
    v.rst = r; v.malu = a; v.mb = d; v.mrn = rn; v.mwreg = wr; v.mm2reg = m2r;
    v.mwmem = wm; v.chk_wmo = cw; v.exp_wmo = ew; v.name = n;
    return v;
  endfunction

  vec_t tbl[$];
  vec_t rv;
  logic [31:0] aligned_ld;

  initial begin
    for (int i = 0; i < 256; i++) begin
      known[i]     = 1'b0;
      model_mem[i] = '0;
    end
    rst = 1'b1;
    bus.malu = '0; bus.mb = '0; bus.mrn = '0;
    bus.mwreg = 1'b0; bus.mm2reg = 1'b0; bus.mwmem = 1'b0;

`ifdef MEM_ALIGN_CHECK_EN
    aligned_ld = 32'h1234_5678;
`else
    aligned_ld = 32'h7777_7777;
`endif

    //                 rst  malu          mb            rn  wr m2r wm chk exp_wmo
    tbl.push_back(mk(1, 32'h0,        32'h0,        0,  0, 0, 0, 1, 32'h0,          "rst_idle"));
    tbl.push_back(mk(0, 32'h10,       32'h0BAD_F00D, 0, 0, 0, 1, 0, 32'h0,          "pre_store10"));
    tbl.push_back(mk(1, 32'h10,       32'hDEAD_BEEF, 7, 1, 0, 1, 1, 32'h0,          "rst_store_a"));
    tbl.push_back(mk(1, 32'h10,       32'hDEAD_BEEF, 7, 1, 0, 1, 1, 32'h0,          "rst_store_b"));
    tbl.push_back(mk(0, 32'h10,       32'h0,        3,  1, 1, 0, 1, 32'h0BAD_F00D,  "load10_after_rst"));
    tbl.push_back(mk(0, 32'h20,       32'h1234_5678, 0, 0, 0, 1, 0, 32'h0,          "store20"));
    tbl.push_back(mk(0, 32'h20,       32'h0,        5,  1, 1, 0, 1, 32'h1234_5678,  "load20"));
    tbl.push_back(mk(0, 32'h8,        32'hAAAA_AAAA, 0, 0, 0, 1, 0, 32'h0,          "store8_a"));
    tbl.push_back(mk(0, 32'h8,        32'h5555_5555, 0, 0, 0, 1, 1, 32'hAAAA_AAAA,  "rdw_old_data"));
    tbl.push_back(mk(0, 32'h8,        32'h0,        9,  1, 1, 0, 1, 32'h5555_5555,  "load8_new"));
    tbl.push_back(mk(0, 32'h404,      32'hCAFE_0001, 0, 0, 0, 1, 0, 32'h0,          "store404"));
    tbl.push_back(mk(0, 32'h004,      32'h0,        2,  1, 1, 0, 1, 32'hCAFE_0001,  "alias_load004"));
    tbl.push_back(mk(0, 32'h3FC,      32'h600D_0000, 0, 0, 0, 1, 0, 32'h0,          "store3fc"));
    tbl.push_back(mk(0, 32'hFFFF_FFFF, 32'h0,       31, 1, 0, 0, 1, 32'h600D_0000,  "alu_pass"));
    tbl.push_back(mk(0, 32'h3FC,      32'h0,        4,  1, 1, 0, 1, 32'h600D_0000,  "load3fc_unchanged"));
    tbl.push_back(mk(0, 32'h22,       32'h7777_7777, 0, 0, 0, 1, 1, 32'h1234_5678,  "misaligned_store"));
    tbl.push_back(mk(0, 32'h20,       32'h0,        6,  1, 1, 0, 1, aligned_ld,     "load20_after_mis"));
    tbl.push_back(mk(0, 32'h21,       32'h0,        8,  1, 1, 0, 1, aligned_ld,     "misaligned_load"));
    tbl.push_back(mk(0, 32'h0,        32'h0,        0,  0, 0, 0, 0, 32'h0,          "bubble"));
    tbl.push_back(mk(0, 32'h30,       32'h2222_2222, 0, 0, 0, 1, 0, 32'h0,          "store30"));
    tbl.push_back(mk(1, 32'h30,       32'h1111_1111, 1, 1, 0, 1, 1, 32'h0,          "midstream_rst"));
    tbl.push_back(mk(0, 32'h30,       32'h0,        1,  1, 1, 0, 1, 32'h2222_2222,  "load30_after_rst"));

    foreach (tbl[i]) step(tbl[i]);

    // Randomized mix of stores, loads, ALU ops and occasional reset on a few words.
    for (int n = 0; n < 60; n++) begin
      rv.rst     = ($urandom_range(0, 15) == 0);
      rv.malu    = 32'h40 + ($urandom_range(0, 3) << 2) + ($urandom_range(0, 1) << 10);
      rv.mb      = $urandom;
      rv.mrn     = 5'($urandom_range(0, 31));
      rv.mwmem   = ($urandom_range(0, 2) == 0);
      rv.mm2reg  = !rv.mwmem && ($urandom_range(0, 1) == 1);
      rv.mwreg   = !rv.mwmem;
      rv.chk_wmo = 1'b0;
      rv.exp_wmo = '0;
      rv.name    = "rand";
      step(rv);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
